seq_alu: RTL and testbench

- Parametrised, registered successor to the 16-bit combinational ALU.
- Same opcode map: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, LLB, LHB.
- Adds generic datapath width, signed saturation on ADD/SUB, and variable-amount shifts/rotates executed iteratively over several cycles.
- Adds a valid/ready input handshake and a registered Z/V/N flag register. It sits between decode and writeback in the pipelined core.

---
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_alu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with saturating add/sub, lane/byte ops and iterative shifts.
// Accepts one operation per cycle when idle; shifts longer than STEP hold in_ready low until done.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int NBYTE = WIDTH / 8;
  localparam int NLANE = WIDTH / 4;
  localparam logic [SW-1:0] STEP_AMT = SW'(STEP);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [SW-1:0]    rem, rem_nxt, step_amt;
  logic [1:0]       kind, kind_nxt;
  logic [SW-1:0]    shamt;
  logic             done, err_nxt, z_nxt, v_nxt, n_nxt;
  logic [WIDTH-1:0] res_nxt, sh_r, red_sum, lane_sum;
  logic [WIDTH:0]   add_r;
  logic [4:0]       lane_t;

  assign shamt    = b[SW-1:0];
  assign in_ready = (state == IDLE) && !rst;

  // kind: 00 SLL, 01 SRA, 10 ROR (low opcode bits)
  function automatic logic [WIDTH-1:0] shift_by(input logic [1:0] k,
                                                input logic [WIDTH-1:0] v,
                                                input logic [SW-1:0] amt);
    case (k)
      2'b00:   shift_by = v << amt;
      2'b01:   shift_by = $signed(v) >>> amt;
      default: shift_by = (v >> amt) | (v << ((SW+1)'(WIDTH) - {1'b0, amt}));
    endcase
  endfunction

  // Returns {overflow, saturated value}; subtraction is a + ~b + 1.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic sub);
    logic [WIDTH-1:0] yy, s;
    logic ovf;
    yy  = sub ? ~y : y;
    s   = x + yy + WIDTH'(sub);
    ovf = (x[WIDTH-1] == yy[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    if (ovf) s = x[WIDTH-1] ? MIN_NEG : MAX_POS;
    return {ovf, s};
  endfunction

  always_comb begin
    red_sum  = '0;
    lane_sum = '0;
    lane_t   = '0;
    for (int i = 0; i < NBYTE; i++) begin
      red_sum = red_sum + {{(WIDTH-8){a[8*i+7]}}, a[8*i +: 8]}
                        + {{(WIDTH-8){b[8*i+7]}}, b[8*i +: 8]};
    end
    for (int i = 0; i < NLANE; i++) begin
      lane_t = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (lane_t[4] != lane_t[3]) lane_sum[4*i +: 4] = lane_t[4] ? 4'h8 : 4'h7;
      else                        lane_sum[4*i +: 4] = lane_t[3:0];
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    kind_nxt  = kind;
    done      = 1'b0;
    err_nxt   = 1'b0;
    res_nxt   = result;
    z_nxt     = flag_z;
    v_nxt     = flag_v;
    n_nxt     = flag_n;
    add_r     = '0;
    step_amt  = '0;
    sh_r      = '0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        done = 1'b1;
        case (opcode)
          4'b0000, 4'b0001: begin
            add_r   = sat_add(a, b, opcode[0]);
            res_nxt = add_r[WIDTH-1:0];
            z_nxt   = (add_r[WIDTH-1:0] == '0);
            v_nxt   = add_r[WIDTH];
            n_nxt   = add_r[WIDTH-1];
          end
          4'b0010: begin
            res_nxt = a ^ b;
            z_nxt   = ((a ^ b) == '0);
          end
          4'b0011: res_nxt = red_sum;
          4'b0100, 4'b0101, 4'b0110: begin
            // First step happens on the accept edge so latency is ceil(shamt/STEP).
            step_amt = (shamt > STEP_AMT) ? STEP_AMT : shamt;
            sh_r     = shift_by(opcode[1:0], a, step_amt);
            if (shamt > STEP_AMT) begin
              done      = 1'b0;
              state_nxt = SHIFT;
              work_nxt  = sh_r;
              rem_nxt   = shamt - STEP_AMT;
              kind_nxt  = opcode[1:0];
            end else begin
              res_nxt = sh_r;
              z_nxt   = (sh_r == '0);
            end
          end
          4'b0111: res_nxt = lane_sum;
          4'b1010: res_nxt = {a[WIDTH-1:8], imm};
          4'b1011: res_nxt = {imm, a[WIDTH-9:0]};
          default: begin
            res_nxt = '0;
            err_nxt = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        step_amt = (rem > STEP_AMT) ? STEP_AMT : rem;
        sh_r     = shift_by(kind, work, step_amt);
        work_nxt = sh_r;
        rem_nxt  = rem - step_amt;
        if (rem == step_amt) begin
          done      = 1'b1;
          res_nxt   = sh_r;
          z_nxt     = (sh_r == '0);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      rem       <= '0;
      kind      <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
      flag_n    <= 1'b0;
    end else begin
      work      <= work_nxt;
      rem       <= rem_nxt;
      kind      <= kind_nxt;
      out_valid <= done;
      err       <= err_nxt;
      result    <= res_nxt;
      flag_z    <= z_nxt;
      flag_v    <= v_nxt;
      flag_n    <= n_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: three instances (16/STEP1, 16/STEP4, 32/STEP1).
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  opcode = 4'h0;
  logic [7:0]  imm = 8'h00;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        vld_u = 1'b0, vld_s = 1'b0, vld_w = 1'b0;

  logic        u_rdy, u_ov, u_z, u_v, u_n, u_err;
  logic [15:0] u_res;
  logic        s_rdy, s_ov, s_z, s_v, s_n, s_err;
  logic [15:0] s_res;
  logic        w_rdy, w_ov, w_z, w_v, w_n, w_err;
  logic [31:0] w_res;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(16), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(vld_u), .in_ready(u_rdy), .opcode(opcode),
    .a(a16), .b(b16), .imm(imm), .out_valid(u_ov), .result(u_res),
    .flag_z(u_z), .flag_v(u_v), .flag_n(u_n), .err(u_err));

  seq_alu #(.WIDTH(16), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(vld_s), .in_ready(s_rdy), .opcode(opcode),
    .a(a16), .b(b16), .imm(imm), .out_valid(s_ov), .result(s_res),
    .flag_z(s_z), .flag_v(s_v), .flag_n(s_n), .err(s_err));

  seq_alu #(.WIDTH(32), .STEP(1)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(vld_w), .in_ready(w_rdy), .opcode(opcode),
    .a(a32), .b(b32), .imm(imm), .out_valid(w_ov), .result(w_res),
    .flag_z(w_z), .flag_v(w_v), .flag_n(w_n), .err(w_err));

  function automatic logic ov_of(input int unit);
    return (unit == 0) ? u_ov : (unit == 1) ? s_ov : w_ov;
  endfunction

  function automatic logic rdy_of(input int unit);
    return (unit == 0) ? u_rdy : (unit == 1) ? s_rdy : w_rdy;
  endfunction

  // Present one op for one cycle; returns at the sample point of the cycle after accept.
  task automatic drive(input int unit, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [7:0] iv);
    @(negedge clk);
    opcode = op; imm = iv;
    a16 = av[15:0]; b16 = bv[15:0]; a32 = av; b32 = bv;
    vld_u = (unit == 0); vld_s = (unit == 1); vld_w = (unit == 2);
    @(negedge clk);
    vld_u = 1'b0; vld_s = 1'b0; vld_w = 1'b0;
  endtask

  // Bounded wait for out_valid; counts cycles and how often in_ready was high meanwhile.
  task automatic wait_done(input int unit, output int lat, output int rdy_hits);
    lat = 1;
    rdy_hits = 0;
    while (!ov_of(unit) && lat < 64) begin
      if (rdy_of(unit)) rdy_hits++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    int lat, rh, pulses;
    @(negedge clk);
    n_cmp++;
    if ({u_rdy, u_ov, u_res, u_z, u_v, u_n, u_err} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b ov=%b res=%h flags=%b%b%b err=%b, want all 0",
               u_rdy, u_ov, u_res, u_z, u_v, u_n, u_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (u_rdy !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", u_rdy); end
    drive(0, 4'b0000, 32'h7FF0, 32'h0020, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_v} !== {16'h7FFF, 1'b1}) begin
      n_bad++; $display("FAIL pre_reset_add: got %h v=%b want 7fff v=1", u_res, u_v);
    end
    drive(0, 4'b0100, 32'h0001, 32'd9, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({u_ov, u_rdy, u_res, u_z, u_v, u_n} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_mid_shift: got ov=%b rdy=%b res=%h flags=%b%b%b want all 0",
               u_ov, u_rdy, u_res, u_z, u_v, u_n);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (u_rdy !== 1'b1) begin n_bad++; $display("FAIL ready_after_abort: got %b want 1", u_rdy); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (u_ov) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL aborted_shift_pulse: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_saturation;
    int lat, rh;
    drive(0, 4'b0000, 32'h7FF0, 32'h0020, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, u_res, u_z, u_v, u_n, u_err} !== {32'd1, 16'h7FFF, 4'b0100}) begin
      n_bad++; $display("FAIL add_sat_pos: got lat=%0d res=%h zvn=%b%b%b err=%b want 1 7fff 010 0",
                        lat, u_res, u_z, u_v, u_n, u_err);
    end
    drive(0, 4'b0001, 32'h8000, 32'h0001, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, u_res, u_z, u_v, u_n} !== {32'd1, 16'h8000, 3'b011}) begin
      n_bad++; $display("FAIL sub_sat_neg: got lat=%0d res=%h zvn=%b%b%b want 1 8000 011",
                        lat, u_res, u_z, u_v, u_n);
    end
    drive(0, 4'b0000, 32'h0003, 32'hFFFD, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_z, u_v, u_n} !== {16'h0000, 3'b100}) begin
      n_bad++; $display("FAIL add_zero: got res=%h zvn=%b%b%b want 0000 100", u_res, u_z, u_v, u_n);
    end
  endtask

  task automatic test_shift_step1;
    int lat, rh, pulses;
    drive(0, 4'b0101, 32'h8001, 32'd4, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, rh, u_res, u_z, u_v, u_n} !== {32'd4, 32'd0, 16'hF800, 3'b000}) begin
      n_bad++; $display("FAIL sra4: got lat=%0d rdy_hits=%0d res=%h zvn=%b%b%b want 4 0 f800 000",
                        lat, rh, u_res, u_z, u_v, u_n);
    end
    drive(0, 4'b0110, 32'h0001, 32'd15, 8'h00);
    // An op offered mid-shift must be dropped, not queued.
    vld_u = 1'b1; opcode = 4'b0010; a16 = 16'h5555; b16 = 16'h0F0F;
    @(negedge clk);
    vld_u = 1'b0;
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat + 1, rh, u_res} !== {32'd15, 32'd0, 16'h0002}) begin
      n_bad++; $display("FAIL ror15: got lat=%0d rdy_hits=%0d res=%h want 15 0 0002", lat + 1, rh, u_res);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (u_ov) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL busy_op_ignored: got %0d extra pulses want 0", pulses); end
    drive(0, 4'b0100, 32'h1234, 32'd0, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, u_res} !== {32'd1, 16'h1234}) begin
      n_bad++; $display("FAIL sll0: got lat=%0d res=%h want 1 1234", lat, u_res);
    end
    drive(0, 4'b0100, 32'h4001, 32'd1, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, u_res, u_z, u_v, u_n} !== {32'd1, 16'h8002, 3'b000}) begin
      n_bad++; $display("FAIL sll1: got lat=%0d res=%h zvn=%b%b%b want 1 8002 000",
                        lat, u_res, u_z, u_v, u_n);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    opcode = 4'b0010; a16 = 16'h00FF; b16 = 16'h00FF; vld_u = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({u_ov, u_res, u_z} !== {1'b1, 16'h0000, 1'b1}) begin
      n_bad++; $display("FAIL b2b_xor: got ov=%b res=%h z=%b want 1 0000 1", u_ov, u_res, u_z);
    end
    opcode = 4'b1010; a16 = 16'h12AB; imm = 8'hCD;
    @(negedge clk);
    n_cmp++;
    if ({u_ov, u_res, u_z} !== {1'b1, 16'h12CD, 1'b1}) begin
      n_bad++; $display("FAIL b2b_llb: got ov=%b res=%h z=%b want 1 12cd 1", u_ov, u_res, u_z);
    end
    vld_u = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({u_ov, u_res} !== {1'b0, 16'h12CD}) begin
      n_bad++; $display("FAIL b2b_hold: got ov=%b res=%h want 0 12cd", u_ov, u_res);
    end
  endtask

  task automatic test_lanes_reduction;
    int lat, rh;
    drive(0, 4'b1011, 32'h12AB, 32'h0, 8'hCD);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_z} !== {16'hCDAB, 1'b1}) begin
      n_bad++; $display("FAIL lhb: got res=%h z=%b want cdab 1", u_res, u_z);
    end
    drive(0, 4'b0111, 32'h7878, 32'h1111, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_z, u_v, u_n} !== {16'h7979, 3'b100}) begin
      n_bad++; $display("FAIL paddsb_sat: got res=%h zvn=%b%b%b want 7979 100", u_res, u_z, u_v, u_n);
    end
    drive(0, 4'b0111, 32'h8888, 32'h8888, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if (u_res !== 16'h8888) begin n_bad++; $display("FAIL paddsb_neg: got %h want 8888", u_res); end
    drive(0, 4'b0111, 32'h1234, 32'h1111, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if (u_res !== 16'h2345) begin n_bad++; $display("FAIL paddsb_plain: got %h want 2345", u_res); end
    drive(0, 4'b0011, 32'h7F7F, 32'h0102, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_z, u_v, u_n} !== {16'h0101, 3'b100}) begin
      n_bad++; $display("FAIL red16: got res=%h zvn=%b%b%b want 0101 100", u_res, u_z, u_v, u_n);
    end
    drive(0, 4'b0011, 32'h8080, 32'hFFFF, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if (u_res !== 16'hFEFE) begin n_bad++; $display("FAIL red16_neg: got %h want fefe", u_res); end
  endtask

  task automatic test_undefined;
    int lat, rh;
    drive(0, 4'b0000, 32'h7FF0, 32'h0020, 8'h00);
    wait_done(0, lat, rh);
    drive(0, 4'b1100, 32'hFFFF, 32'hFFFF, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({lat, u_res, u_err, u_z, u_v, u_n} !== {32'd1, 16'h0000, 4'b1010}) begin
      n_bad++; $display("FAIL undef_1100: got lat=%0d res=%h err=%b zvn=%b%b%b want 1 0000 1 010",
                        lat, u_res, u_err, u_z, u_v, u_n);
    end
    @(negedge clk);
    n_cmp++;
    if ({u_ov, u_err} !== 2'b00) begin
      n_bad++; $display("FAIL undef_pulse: got ov=%b err=%b want 0 0", u_ov, u_err);
    end
    drive(0, 4'b1000, 32'h1234, 32'h0001, 8'h00);
    wait_done(0, lat, rh);
    n_cmp++;
    if ({u_res, u_err} !== {16'h0000, 1'b1}) begin
      n_bad++; $display("FAIL undef_1000: got res=%h err=%b want 0000 1", u_res, u_err);
    end
  endtask

  task automatic test_step4;
    int lat, rh;
    drive(1, 4'b0100, 32'h0001, 32'd15, 8'h00);
    wait_done(1, lat, rh);
    n_cmp++;
    if ({lat, rh, s_res, s_z} !== {32'd4, 32'd0, 16'h8000, 1'b0}) begin
      n_bad++; $display("FAIL step4_sll15: got lat=%0d rdy_hits=%0d res=%h z=%b want 4 0 8000 0",
                        lat, rh, s_res, s_z);
    end
    drive(1, 4'b0101, 32'h8000, 32'd6, 8'h00);
    wait_done(1, lat, rh);
    n_cmp++;
    if ({lat, s_res} !== {32'd2, 16'hFE00}) begin
      n_bad++; $display("FAIL step4_sra6: got lat=%0d res=%h want 2 fe00", lat, s_res);
    end
  endtask

  task automatic test_width32;
    int lat, rh;
    drive(2, 4'b0011, 32'h7F7F7F7F, 32'h01020304, 8'h00);
    wait_done(2, lat, rh);
    n_cmp++;
    if ({lat, w_res} !== {32'd1, 32'h00000206}) begin
      n_bad++; $display("FAIL red32: got lat=%0d res=%h want 1 00000206", lat, w_res);
    end
    drive(2, 4'b0011, 32'h80808080, 32'h80808080, 8'h00);
    wait_done(2, lat, rh);
    n_cmp++;
    if (w_res !== 32'hFFFFFC00) begin n_bad++; $display("FAIL red32_neg: got %h want fffffc00", w_res); end
    drive(2, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 8'h00);
    wait_done(2, lat, rh);
    n_cmp++;
    if ({w_res, w_z, w_v, w_n} !== {32'h7FFFFFFF, 3'b010}) begin
      n_bad++; $display("FAIL add32_sat: got res=%h zvn=%b%b%b want 7fffffff 010", w_res, w_z, w_v, w_n);
    end
  endtask

  initial begin
    test_reset;
    test_saturation;
    test_shift_step1;
    test_back_to_back;
    test_lanes_reduction;
    test_undefined;
    test_step4;
    test_width32;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
